// File: rtl/uart_rx_param_if.sv
// Serial input and received-word signals of the parametrised UART receiver.
// The receiver connects through the master modport, the consumer/line driver through slave.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver with configurable rate, word width, parity and stop bits.
// Each bit is the 3-sample majority taken at the end of its bit window.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input logic             i_Clock,
    input logic             i_Reset,
    uart_rx_param_if.master rx_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_V0   = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] CNT_V1   = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_CLEANUP = 3'd5;

    logic                 rx_meta, rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [1:0]           votes;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, par_err, stop_err, stop0;
    logic                 bit_val, commit, stop_first, stop_err_nxt, brk_now;

    // The third vote is rx_s itself on the commit cycle.
    always_comb begin
        bit_val      = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
        commit       = (cnt == CNT_LAST);
        stop_first   = (bit_idx == '0) ? bit_val : stop0;
        stop_err_nxt = ((bit_idx == '0) ? 1'b0 : stop_err) | ~bit_val;
        brk_now      = (shift == '0) && (PARITY == 0 || !par_bit) && !stop_first;
    end

    assign rx_if.o_Busy = (state != S_IDLE);

    // NOTE: the synchroniser resets to the idle line level so reset release cannot fake a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: all state uses non-blocking assignments; later assignments in a branch override the defaults above them.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state              <= S_IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            votes              <= '0;
            shift              <= '0;
            par_bit            <= 1'b0;
            par_err            <= 1'b0;
            stop_err           <= 1'b0;
            stop0              <= 1'b0;
            rx_if.o_Rx_DV      <= 1'b0;
            rx_if.o_Rx_Byte    <= '0;
            rx_if.o_Parity_Err <= 1'b0;
            rx_if.o_Frame_Err  <= 1'b0;
            rx_if.o_Break      <= 1'b0;
        end else begin
            rx_if.o_Rx_DV <= 1'b0;
            cnt           <= cnt + 1'b1;
            if (state == S_DATA || state == S_PARITY || state == S_STOP) begin
                if (cnt == CNT_V0) votes[0] <= rx_s;
                if (cnt == CNT_V1) votes[1] <= rx_s;
            end
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    votes   <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (commit) begin
                        cnt            <= '0;
                        shift[bit_idx] <= bit_val;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (commit) begin
                        cnt     <= '0;
                        par_bit <= bit_val;
                        par_err <= ((^shift) ^ bit_val) != (PARITY == 1);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (commit) begin
                        cnt      <= '0;
                        stop_err <= stop_err_nxt;
                        if (bit_idx == '0) stop0 <= bit_val;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx            <= '0;
                            rx_if.o_Rx_DV      <= 1'b1;
                            rx_if.o_Rx_Byte    <= shift;
                            rx_if.o_Parity_Err <= brk_now ? 1'b0 : par_err;
                            rx_if.o_Frame_Err  <= stop_err_nxt | brk_now;
                            rx_if.o_Break      <= brk_now;
                            state              <= S_CLEANUP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_CLEANUP: begin
                    // Wait for the line to return high so a break cannot retrigger a start.
                    cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
